// File: rtl/rca_pkg.sv
// rtl/rca_pkg.sv - shared constants and stage control payload for the pipelined adder
package rca_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SEG   = 4;

    // Per-stage control travelling alongside the operand/sum registers.
    // msb_ci is the carry into the top bit of the segment just resolved;
    // only the last stage's copy is used, to form signed overflow.
    typedef struct packed {
        logic valid;
        logic carry;
        logic msb_ci;
    } stage_ctl_t;

endpackage

// File: rtl/rca_pipe_fa_cell.sv
// rtl/rca_pipe_fa_cell.sv - one-bit full adder used to build each segment's ripple chain
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/rca_pipe.sv
// rtl/rca_pipe.sv - pipelined ripple-carry adder/subtractor, one SEG-bit segment per clock
module rca_pipe
    import rca_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG   = DEF_SEG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / SEG;

    // Index 0 is the input capture register; index k+1 holds the beat after
    // segment k has been resolved. Operands are only needed up to the last
    // resolving stage, so they stop one entry short.
    stage_ctl_t       ctl_q [STAGES+1];
    logic [WIDTH-1:0] s_q   [STAGES+1];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];

    logic [SEG-1:0]   seg_sum [STAGES];
    logic             seg_co  [STAGES];
    logic             seg_cm  [STAGES];

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // Whole pipeline advances together; a stalled output freezes every stage.
    assign adv      = !ctl_q[STAGES].valid || out_ready;
    assign in_ready = adv;

    // Subtraction is a + ~b + 1; the caller's carry-in is ignored then.
    assign b_eff = sub ? ~b : b;
    assign c0    = sub ? 1'b1 : cin;

    // Segment adders: stage g ripples bits [g*SEG +: SEG] from its incoming carry.
    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        for (genvar i = 0; i < SEG; i++) begin : g_bit
            logic ci;
            logic co;
            if (i == 0) begin : g_first
                assign ci = ctl_q[g].carry;
            end else begin : g_rest
                assign ci = g_bit[i-1].co;
            end
            fa_cell u_fa (
                .a  (a_q[g][g*SEG + i]),
                .b  (b_q[g][g*SEG + i]),
                .ci (ci),
                .s  (seg_sum[g][i]),
                .co (co)
            );
        end
        assign seg_co[g] = g_bit[SEG-1].co;
        assign seg_cm[g] = g_bit[SEG-1].ci;
    end

    // Pipeline registers: load on advance, hold on stall, clear on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= STAGES; k++) begin
                ctl_q[k] <= '0;
                s_q[k]   <= '0;
            end
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
        end else if (adv) begin
            ctl_q[0] <= '{valid: in_valid, carry: c0, msb_ci: 1'b0};
            a_q[0]   <= a;
            b_q[0]   <= b_eff;
            for (int k = 1; k < STAGES; k++) begin
                a_q[k] <= a_q[k-1];
                b_q[k] <= b_q[k-1];
            end
            for (int k = 0; k < STAGES; k++) begin
                ctl_q[k+1] <= '{valid: ctl_q[k].valid, carry: seg_co[k], msb_ci: seg_cm[k]};
                s_q[k+1]   <= s_q[k];
                s_q[k+1][k*SEG +: SEG] <= seg_sum[k];
            end
        end
    end

    assign out_valid = ctl_q[STAGES].valid;
    assign sum       = s_q[STAGES];
    assign cout      = ctl_q[STAGES].carry;
    assign ovf       = ctl_q[STAGES].msb_ci ^ ctl_q[STAGES].carry;

endmodule
